// File: rtl/i2c_master_arb.sv
// Two-requester I2C master: round-robin grant, one address byte plus one data byte per transaction.
// Open-drain SCL/SDA drives are registered and change only on quarter-bit boundaries.
module i2c_master_arb #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_rw,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_rw,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       done,
    output logic       done_id,
    output logic [7:0] rdata,
    output logic       nack,
    output logic       busy,
    inout  wire        SCL,
    inout  wire        SDA
);

    // state       | meaning
    // S_IDLE      | bus released, waiting for a request
    // S_START     | start condition, 4 quarters
    // S_ADDR_BITS | 7 address bits then rw, MSB first
    // S_ADDR_ACK  | SDA released, slave acknowledge sampled
    // S_DATA_BITS | write byte driven or read byte sampled
    // S_DATA_ACK  | SDA released; write: slave ack sampled, read: master NACK
    // S_STOP      | stop condition, done pulses at its end
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR_BITS,
        S_ADDR_ACK,
        S_DATA_BITS,
        S_DATA_ACK,
        S_STOP
    } state_t;

    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);

    state_t      state;
    state_t      nxt_state;
    logic [1:0]  qtr;
    logic [1:0]  nxt_qtr;
    logic [2:0]  bit_idx;
    logic [2:0]  nxt_bit;
    logic [15:0] div_cnt;
    logic        tick;
    logic [7:0]  addr_byte;
    logic [7:0]  wdata_q;
    logic [7:0]  rx_shift;
    logic        rw_q;
    logic        cur_id;
    logic        last_id;
    logic        nack_pend;
    logic        scl_low;
    logic        sda_low;
    logic        sda_in;
    logic        grant_any;
    logic        grant_id;

    assign SCL    = scl_low ? 1'b0 : 1'bz;
    assign SDA    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = SDA;

    assign tick      = (div_cnt == 16'd0);
    assign grant_any = (state == S_IDLE) && !busy && (req0_valid || req1_valid);
    // With both valid, the requester not served last wins; otherwise the only valid one.
    assign grant_id  = (req0_valid && req1_valid) ? ~last_id : ~req0_valid;

    always_comb begin
        nxt_state = state;
        nxt_qtr   = qtr + 2'd1;
        nxt_bit   = bit_idx;
        if (qtr == 2'd3) begin
            case (state)
                S_START: begin
                    nxt_state = S_ADDR_BITS;
                    nxt_bit   = 3'd0;
                end
                S_ADDR_BITS: begin
                    if (bit_idx == 3'd7) nxt_state = S_ADDR_ACK;
                    else                 nxt_bit   = bit_idx + 3'd1;
                end
                S_ADDR_ACK: begin
                    nxt_state = sda_in ? S_STOP : S_DATA_BITS;
                    nxt_bit   = 3'd0;
                end
                S_DATA_BITS: begin
                    if (bit_idx == 3'd7) nxt_state = S_DATA_ACK;
                    else                 nxt_bit   = bit_idx + 3'd1;
                end
                S_DATA_ACK: nxt_state = S_STOP;
                default:    nxt_state = S_IDLE;
            endcase
        end
    end

    // Returns {scl_low, sda_low} for the quarter being entered.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                             input logic [2:0] b, input logic rw,
                                             input logic [7:0] ab, input logic [7:0] wb);
        logic q_low;
        logic [1:0] drv;
        q_low = (q < 2'd2);
        drv   = 2'b00;
        case (st)
            S_START: begin
                if (q == 2'd0)      drv = 2'b00;
                else if (q == 2'd3) drv = 2'b11;
                else                drv = 2'b01;
            end
            S_ADDR_BITS: drv = {q_low, ~ab[~b]};
            S_DATA_BITS: drv = {q_low, ~rw & ~wb[~b]};
            S_ADDR_ACK,
            S_DATA_ACK:  drv = {q_low, 1'b0};
            S_STOP: begin
                if (q == 2'd0)      drv = 2'b11;
                else if (q == 2'd1) drv = 2'b01;
                else                drv = 2'b00;
            end
            default: drv = 2'b00;
        endcase
        return drv;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            qtr        <= 2'd0;
            bit_idx    <= 3'd0;
            div_cnt    <= 16'd0;
            addr_byte  <= 8'd0;
            wdata_q    <= 8'd0;
            rx_shift   <= 8'd0;
            rw_q       <= 1'b0;
            cur_id     <= 1'b0;
            last_id    <= 1'b1;
            nack_pend  <= 1'b0;
            scl_low    <= 1'b0;
            sda_low    <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            rdata      <= 8'd0;
            nack       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            done       <= 1'b0;
            if (state == S_IDLE) begin
                if (grant_any) begin
                    state      <= S_START;
                    qtr        <= 2'd0;
                    bit_idx    <= 3'd0;
                    div_cnt    <= DIV_LOAD;
                    req0_ready <= ~grant_id;
                    req1_ready <= grant_id;
                    last_id    <= grant_id;
                    cur_id     <= grant_id;
                    rw_q       <= grant_id ? req1_rw : req0_rw;
                    addr_byte  <= grant_id ? {req1_addr, req1_rw} : {req0_addr, req0_rw};
                    wdata_q    <= grant_id ? req1_wdata : req0_wdata;
                    rx_shift   <= 8'd0;
                    nack_pend  <= 1'b0;
                    scl_low    <= 1'b0;
                    sda_low    <= 1'b0;
                end
            end else begin
                if (req0_ready || req1_ready) busy <= 1'b1;
                if (tick) begin
                    div_cnt <= DIV_LOAD;
                    state   <= nxt_state;
                    qtr     <= nxt_qtr;
                    bit_idx <= nxt_bit;
                    {scl_low, sda_low} <= bus_drive(nxt_state, nxt_qtr, nxt_bit,
                                                    rw_q, addr_byte, wdata_q);
                    if (qtr == 2'd3) begin
                        if (state == S_ADDR_ACK && sda_in) nack_pend <= 1'b1;
                        if (state == S_DATA_BITS && rw_q) rx_shift <= {rx_shift[6:0], sda_in};
                        if (state == S_DATA_ACK && !rw_q && sda_in) nack_pend <= 1'b1;
                        if (state == S_STOP) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            done_id <= cur_id;
                            nack    <= nack_pend;
                            if (rw_q) rdata <= rx_shift;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_arb.sv
// Bench for i2c_master_arb: quarter-level bus waveform model, arbitration model and an I2C slave at 0x51.
module tb_i2c_master_arb;

    localparam int D = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h51;
    localparam logic [7:0] SLAVE_DATA = 8'h3C;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req0_rw;
    logic [6:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       req1_valid, req1_ready, req1_rw;
    logic [6:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       done, done_id, nack, busy;
    logic [7:0] rdata;
    wire        scl_bus;
    wire        sda_bus;
    logic       sl_low = 1'b0;

    pullup(scl_bus);
    pullup(sda_bus);
    assign sda_bus = sl_low ? 1'b0 : 1'bz;

    i2c_master_arb #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .done(done), .done_id(done_id), .rdata(rdata), .nack(nack), .busy(busy),
        .SCL(scl_bus), .SDA(sda_bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic lvl(input logic x);
        return (x !== 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- slave on the bus, sampled away from the clock edge ----------------
    logic [7:0] bus_bytes[$];
    bit         bits_q[$];
    int         stop_cnt = 0;
    int         s_cnt = 100;
    logic [7:0] s_sh = 8'd0;
    logic [7:0] s_dat = SLAVE_DATA;
    bit         s_match = 1'b0;
    bit         s_rd = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1, s_c, s_d;

    always @(negedge clk) begin
        s_c = lvl(scl_bus);
        s_d = lvl(sda_bus);
        if (p_scl && s_c && p_sda && !s_d) begin
            s_cnt = 0; s_match = 1'b0; sl_low = 1'b0;
            bus_bytes.delete(); bits_q.delete();
        end else if (p_scl && s_c && !p_sda && s_d) begin
            stop_cnt++;
        end else if (!p_scl && s_c) begin
            s_cnt++;
            s_sh = {s_sh[6:0], s_d};
            bits_q.push_back(s_d);
            if (s_cnt == 8 || s_cnt == 17) bus_bytes.push_back(s_sh);
        end else if (p_scl && !s_c) begin
            if (s_cnt == 8) begin
                s_match = (s_sh[7:1] == SLAVE_ADDR);
                s_rd    = s_sh[0];
                sl_low  = s_match;
            end else if (s_match && s_rd && s_cnt >= 9 && s_cnt <= 16) begin
                sl_low = !s_dat[16 - s_cnt];
            end else if (s_match && !s_rd && s_cnt == 17) begin
                sl_low = 1'b1;
            end else begin
                sl_low = 1'b0;
            end
        end
        p_scl = s_c;
        p_sda = s_d;
    end

    // ---------------- behavioural model: expected bus level per quarter ----------------
    bit         e_scl[0:79];
    bit         e_sda[0:79];
    int         m_nq = 0;
    bit         m_in_txn = 1'b0;
    int         m_k = 0;
    bit         m_last = 1'b1;
    bit         m_id = 1'b0, m_rw = 1'b0, m_pend_nack = 1'b0;
    logic [7:0] m_pend_rdata = 8'd0;
    bit         m_done_id = 1'b0, m_nack = 1'b0;
    logic [7:0] m_rdata = 8'd0;
    bit         er0, er1, gid, e_busy, e_done;
    int         lim;

    task automatic add_q(input bit c, input bit d);
        e_scl[m_nq] = c;
        e_sda[m_nq] = d;
        m_nq++;
    endtask

    task automatic add_bit(input bit v);
        add_q(1'b0, v); add_q(1'b0, v); add_q(1'b1, v); add_q(1'b1, v);
    endtask

    task automatic start_txn(input bit id);
        logic [6:0] a;
        logic [7:0] ab, db;
        bit ack;
        m_id = id;
        m_rw = id ? req1_rw : req0_rw;
        a    = id ? req1_addr : req0_addr;
        ab   = {a, m_rw};
        db   = m_rw ? SLAVE_DATA : (id ? req1_wdata : req0_wdata);
        ack  = (a == SLAVE_ADDR);
        m_nq = 0;
        add_q(1, 1); add_q(1, 0); add_q(1, 0); add_q(0, 0);
        for (int i = 7; i >= 0; i--) add_bit(ab[i]);
        add_bit(!ack);
        if (ack) begin
            for (int i = 7; i >= 0; i--) add_bit(db[i]);
            add_bit(m_rw);
        end
        add_q(0, 0); add_q(1, 0); add_q(1, 1); add_q(1, 1);
        m_pend_nack  = !ack;
        m_pend_rdata = (m_rw && ack) ? SLAVE_DATA : 8'd0;
        m_in_txn = 1'b1;
        m_k = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("rst_scl", lvl(scl_bus), 1);
            chk("rst_sda", lvl(sda_bus), 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_done_id", done_id, 0);
            chk("rst_nack", nack, 0);
            chk("rst_rdata", rdata, 0);
            m_in_txn = 1'b0; m_last = 1'b1;
            m_done_id = 1'b0; m_nack = 1'b0; m_rdata = 8'd0;
        end else begin
            er0 = 1'b0; er1 = 1'b0;
            if (m_in_txn) begin
                m_k++;
            end else if (req0_valid || req1_valid) begin
                gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
                m_last = gid;
                er0 = !gid; er1 = gid;
                start_txn(gid);
            end
            chk("cmp_ready0", req0_ready, er0);
            chk("cmp_ready1", req1_ready, er1);
            e_busy = 1'b0; e_done = 1'b0;
            if (m_in_txn) begin
                lim    = m_nq * D;
                e_busy = (m_k >= 1 && m_k < lim);
                e_done = (m_k == lim);
                if (m_k < lim) begin
                    chk("cmp_scl", lvl(scl_bus), e_scl[m_k / D]);
                    if (m_k % D != 0) chk("cmp_sda", lvl(sda_bus), e_sda[m_k / D]);
                end else begin
                    chk("cmp_scl_end", lvl(scl_bus), 1);
                    chk("cmp_sda_end", lvl(sda_bus), 1);
                end
                if (e_done) begin
                    m_done_id = m_id;
                    m_nack    = m_pend_nack;
                    if (m_rw) m_rdata = m_pend_rdata;
                    m_in_txn  = 1'b0;
                end
            end else begin
                chk("cmp_scl_idle", lvl(scl_bus), 1);
                chk("cmp_sda_idle", lvl(sda_bus), 1);
            end
            chk("cmp_busy", busy, e_busy);
            chk("cmp_done", done, e_done);
            chk("cmp_done_id", done_id, m_done_id);
            chk("cmp_nack", nack, m_nack);
            chk("cmp_rdata", rdata, m_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] qbyte(input int i);
        return (i < bus_bytes.size()) ? 32'(bus_bytes[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] qbit(input int i);
        return (i < bits_q.size()) ? 32'(bits_q[i]) : 32'hDEAD;
    endfunction

    task automatic do_req(input bit id, input bit rw, input logic [6:0] a,
                          input logic [7:0] wd, output int lat);
        int t0, n;
        @(negedge clk);
        if (id) begin
            req1_rw = rw; req1_addr = a; req1_wdata = wd; req1_valid = 1'b1;
        end else begin
            req0_rw = rw; req0_addr = a; req0_wdata = wd; req0_valid = 1'b1;
        end
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_seen", (id ? req1_ready : req0_ready), 1);
        t0 = cyc;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("req_done_seen", done, 1);
        lat = cyc - t0;
    endtask

    int   lat, stops0, ndone, nrdy, cnt;
    bit   saw_done;
    logic ids[$];

    initial begin
        reset = 1'b0;
        req0_valid = 0; req0_rw = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_rw = 0; req1_addr = 0; req1_wdata = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_scl", lvl(scl_bus), 1);
        reset = 1'b1;

        // write 0x51 <- 0xA5 from requester 0
        do_req(0, 0, 7'h51, 8'hA5, lat);
        chk("t1_done_id", done_id, 0);
        chk("t1_nack", nack, 0);
        chk("t1_latency", lat, 320);
        chk("t1_nbytes", bus_bytes.size(), 2);
        chk("t1_byte0", qbyte(0), 8'hA2);
        chk("t1_byte1", qbyte(1), 8'hA5);

        // read 0x51 from requester 1, slave returns 0x3C
        do_req(1, 1, 7'h51, 8'h00, lat);
        chk("t2_done_id", done_id, 1);
        chk("t2_nack", nack, 0);
        chk("t2_rdata", rdata, 8'h3C);
        chk("t2_latency", lat, 320);
        chk("t2_byte0", qbyte(0), 8'hA3);
        chk("t2_ack9_released", qbit(17), 1);

        // write to an absent address
        stops0 = stop_cnt;
        do_req(1, 0, 7'h22, 8'h5A, lat);
        chk("t3_nack", nack, 1);
        chk("t3_done_id", done_id, 1);
        chk("t3_latency", lat, 176);
        chk("t3_nbytes", bus_bytes.size(), 1);
        chk("t3_byte0", qbyte(0), 8'h44);
        chk("t3_stop", stop_cnt - stops0, 1);
        chk("t3_rdata_hold", rdata, 8'h3C);

        // both requesters held valid for three transactions
        @(negedge clk);
        req0_rw = 0; req0_addr = 7'h51; req0_wdata = 8'h11;
        req1_rw = 1; req1_addr = 7'h51; req1_wdata = 8'h00;
        req0_valid = 1'b1; req1_valid = 1'b1;
        ndone = 0; nrdy = 0; cnt = 0;
        while (ndone < 3 && cnt < 1500) begin
            @(negedge clk);
            cnt++;
            if (req0_ready || req1_ready) nrdy++;
            if (done) begin
                ids.push_back(done_id);
                ndone++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t4_ndone", ndone, 3);
        chk("t4_nready", nrdy, 3);
        chk("t4_id0", (ids.size() > 0) ? 32'(ids[0]) : 32'hDEAD, 0);
        chk("t4_id1", (ids.size() > 1) ? 32'(ids[1]) : 32'hDEAD, 1);
        chk("t4_id2", (ids.size() > 2) ? 32'(ids[2]) : 32'hDEAD, 0);

        // reset in the middle of a write, then a clean transaction
        @(negedge clk);
        req0_rw = 0; req0_addr = 7'h51; req0_wdata = 8'hC3; req0_valid = 1'b1;
        cnt = 0;
        while (!req0_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("t5_ready_seen", req0_ready, 1);
        req0_valid = 1'b0;
        repeat (99) @(negedge clk);
        chk("t5_busy_before_reset", busy, 1);
        reset = 1'b0;
        saw_done = 1'b0;
        @(negedge clk);
        chk("t5_scl_released", lvl(scl_bus), 1);
        chk("t5_sda_released", lvl(sda_bus), 1);
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("t5_no_done", saw_done, 0);
        do_req(0, 0, 7'h51, 8'h3C, lat);
        chk("t5_done_id", done_id, 0);
        chk("t5_nack", nack, 0);
        chk("t5_latency", lat, 320);
        chk("t5_byte1", qbyte(1), 8'h3C);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
